// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encoding, flag bit
// positions inside the 4-bit flags word, and the opcode legality check.
package alu_pkg;

  // Opcode encoding; codes 4'hC..4'hF are reserved and treated as illegal.
  typedef enum logic [3:0] {
    OP_ADD     = 4'h0,
    OP_SUB     = 4'h1,
    OP_AND     = 4'h2,
    OP_OR      = 4'h3,
    OP_XOR     = 4'h4,
    OP_NOT_A   = 4'h5,
    OP_SLL     = 4'h6,
    OP_SRL     = 4'h7,
    OP_SRA     = 4'h8,
    OP_MUL     = 4'h9,
    OP_CMP_LT  = 4'hA,
    OP_CMP_LTU = 4'hB
  } alu_op_t;

  // Bit positions inside flags = {negative, zero, carry, overflow}.
  localparam int unsigned FLAG_NEG   = 3;
  localparam int unsigned FLAG_ZERO  = 2;
  localparam int unsigned FLAG_CARRY = 1;
  localparam int unsigned FLAG_OVF   = 0;

  // True when the code names one of the implemented operations.
  function automatic logic op_is_legal(input logic [3:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT_A,
      OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_CMP_LT, OP_CMP_LTU: legal = 1'b1;
      default:                                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath evaluated on the operands held in pipeline
// stage 1.
// Ports:
//   op      - opcode (alu_op_t encoding)
//   a, b    - operands; for shifts only the low clog2(WIDTH) bits of b count
//   res     - result (zero for illegal opcodes)
//   flags   - {negative, zero, carry, overflow} (zero for illegal opcodes)
//   illegal - opcode is not one of the implemented operations
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0]   shamt_s;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             ovf_s;
  logic             legal_s;

  assign shamt_s = b[SHW-1:0];
  assign add_s   = {1'b0, a} + {1'b0, b};
  // a - b as a + ~b + 1, so the top bit is the carry-out (i.e. NOT borrow).
  assign sub_s   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign legal_s = op_is_legal(op);
  assign illegal = ~legal_s;

  // Operation select plus carry/overflow for the arithmetic ops
  always_comb begin
    res_s   = '0;
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (op)
      OP_ADD: begin
        res_s   = add_s[WIDTH-1:0];
        carry_s = add_s[WIDTH];
        // Same-sign operands producing a result of the other sign.
        ovf_s   = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_s   = sub_s[WIDTH-1:0];
        carry_s = sub_s[WIDTH];
        // Opposite-sign operands where the result sign differs from a.
        ovf_s   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:     res_s = a & b;
      OP_OR:      res_s = a | b;
      OP_XOR:     res_s = a ^ b;
      OP_NOT_A:   res_s = ~a;
      OP_SLL:     res_s = a << shamt_s;
      OP_SRL:     res_s = a >> shamt_s;
      OP_SRA:     res_s = $signed(a) >>> shamt_s;
      OP_MUL:     res_s = a * b;
      OP_CMP_LT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_CMP_LTU: res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      default:    res_s = '0;
    endcase
  end

  // Flag assembly; illegal opcodes report all-zero result and flags
  always_comb begin
    res   = '0;
    flags = 4'h0;
    if (legal_s) begin
      res                = res_s;
      flags[FLAG_NEG]    = res_s[WIDTH-1];
      flags[FLAG_ZERO]   = (res_s == '0);
      flags[FLAG_CARRY]  = carry_s;
      flags[FLAG_OVF]    = ovf_s;
    end else begin
      res   = '0;
      flags = 4'h0;
    end
  end

endmodule

// File: rtl/pipelined_alu.sv
// Pipelined ALU with valid/ready handshakes on both sides.
// Stage 1 registers the accepted operands and evaluates them through
// alu_core; stages 2..STAGES carry the result/flags unchanged. Each stage
// loads when it is empty or its contents are moving on, so bubbles collapse
// and a full pipeline sustains one operation per cycle.
// Ports:
//   clk, rst              - clock; asynchronous active-high reset
//   in_valid/in_ready     - operation handshake (op, a, b)
//   out_valid/out_ready   - result handshake (res, flags)
//   illegal_cnt           - saturating count of illegal opcodes processed
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags,
  output logic [15:0]      illegal_cnt
);

  // valid_s[0] is the upstream offer; valid_s[i] is stage i occupancy.
  logic [STAGES:0]   valid_s;
  // ready_s[i]: stage i may load this cycle; ready_s[STAGES+1] is the consumer.
  logic [STAGES+1:1] ready_s;
  // Result/flags leaving each stage; entry 1 is the live ALU output.
  logic [WIDTH-1:0]  res_pipe_s   [1:STAGES];
  logic [3:0]        flags_pipe_s [1:STAGES];

  logic [3:0]        op_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [WIDTH-1:0]  core_res_s;
  logic [3:0]        core_flags_s;
  logic              core_illegal_s;
  logic [15:0]       illegal_cnt_r;

  assign valid_s[0] = in_valid;
  assign in_ready   = ready_s[1];

  // Ready chain from the consumer back to stage 1; never looks at in_valid
  always_comb begin
    logic rdy_v;
    ready_s           = '0;
    ready_s[STAGES+1] = out_ready;
    rdy_v             = out_ready;
    for (int i = STAGES; i >= 1; i--) begin
      rdy_v      = ~valid_s[i] | rdy_v;
      ready_s[i] = rdy_v;
    end
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op      (op_r),
    .a       (a_r),
    .b       (b_r),
    .res     (core_res_s),
    .flags   (core_flags_s),
    .illegal (core_illegal_s)
  );

  for (genvar i = 1; i <= STAGES; i++) begin : g_stage
    logic valid_r;
    assign valid_s[i] = valid_r;

    if (i == 1) begin : g_head
      // Stage 1: capture the offered operation when the stage can load
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_r <= 1'b0;
          op_r    <= 4'h0;
          a_r     <= '0;
          b_r     <= '0;
        end else if (ready_s[1]) begin
          valid_r <= in_valid;
          op_r    <= op;
          a_r     <= a;
          b_r     <= b;
        end
      end
      assign res_pipe_s[1]   = core_res_s;
      assign flags_pipe_s[1] = core_flags_s;
    end else begin : g_tail
      logic [WIDTH-1:0] res_r;
      logic [3:0]       flags_r;
      // Stages 2..STAGES: carry result and flags forward unchanged
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_r <= 1'b0;
          res_r   <= '0;
          flags_r <= 4'h0;
        end else if (ready_s[i]) begin
          valid_r <= valid_s[i-1];
          res_r   <= res_pipe_s[i-1];
          flags_r <= flags_pipe_s[i-1];
        end
      end
      assign res_pipe_s[i]   = res_r;
      assign flags_pipe_s[i] = flags_r;
    end
  end

  // Count illegal opcodes as they leave stage 1, so each is seen exactly once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt_r <= 16'h0000;
    end else if (valid_s[1] && ready_s[2] && core_illegal_s &&
                 (illegal_cnt_r != 16'hFFFF)) begin
      illegal_cnt_r <= illegal_cnt_r + 16'h0001;
    end
  end

  assign illegal_cnt = illegal_cnt_r;

  // Output view of the last stage; forced to zero while it holds nothing
  always_comb begin
    out_valid = valid_s[STAGES];
    res       = '0;
    flags     = 4'h0;
    if (valid_s[STAGES]) begin
      res   = res_pipe_s[STAGES];
      flags = flags_pipe_s[STAGES];
    end else begin
      res   = '0;
      flags = 4'h0;
    end
  end

endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench: an 8-bit/2-stage and a 32-bit/4-stage instance run
// side by side. Accepted operations are scored against a reference model
// that uses plain integer arithmetic; directed cases cover the corner
// results, back-pressure, illegal opcodes and reset mid-flight.
module tb_pipelined_alu;
  import alu_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst;

  logic        vld8, irdy8, ovld8, ordy8;
  logic [3:0]  op8, flg8;
  logic [7:0]  a8, b8, res8;
  logic [15:0] icnt8;

  logic        vld32, irdy32, ovld32, ordy32;
  logic [3:0]  op32, flg32;
  logic [31:0] a32, b32, res32;
  logic [15:0] icnt32;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  stim_t       pend8[$],  pend32[$];
  logic [67:0] q8[$],     q32[$];
  int          accq8[$],  accq32[$];
  int          accs8 = 0, accs32 = 0, outs8 = 0, outs32 = 0;
  int          exp_icnt8 = 0, exp_icnt32 = 0;
  int          last_lat8 = 0, last_lat32 = 0;
  logic [7:0]  last_res8;
  logic [3:0]  last_flg8, last_flg32;
  logic [31:0] last_res32;
  logic        hold8 = 1'b0, hold32 = 1'b0;
  logic [63:0] hold8_val, hold32_val;

  always #5 clk = ~clk;

  pipelined_alu #(.WIDTH(8), .STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(vld8), .in_ready(irdy8), .op(op8),
    .a(a8), .b(b8), .out_valid(ovld8), .out_ready(ordy8), .res(res8),
    .flags(flg8), .illegal_cnt(icnt8));

  pipelined_alu #(.WIDTH(32), .STAGES(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(vld32), .in_ready(irdy32), .op(op32),
    .a(a32), .b(b32), .out_valid(ovld32), .out_ready(ordy32), .res(res32),
    .flags(flg32), .illegal_cnt(icnt32));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {flags[3:0], res[63:0]} from integer arithmetic at width w.
  function automatic logic [67:0] ref_alu(input int w, input logic [3:0] op,
                                          input logic [63:0] ai, input logic [63:0] bi);
    logic [63:0] mask, a, b, r;
    longint      sa, sb, smax, smin, sres;
    logic        c, v;
    int          sh;
    mask = (64'd1 << w) - 64'd1;
    a    = ai & mask;
    b    = bi & mask;
    sa   = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    smax = longint'((64'd1 << (w - 1)) - 64'd1);
    smin = -smax - 64'sd1;
    sh   = int'(b % 64'(w));
    c    = 1'b0;
    v    = 1'b0;
    r    = 64'd0;
    case (op)
      OP_ADD:     begin r = a + b; c = r[w]; r = r & mask;
                        sres = sa + sb; v = (sres > smax) || (sres < smin); end
      OP_SUB:     begin r = (a - b) & mask; c = (a >= b);
                        sres = sa - sb; v = (sres > smax) || (sres < smin); end
      OP_AND:     r = a & b;
      OP_OR:      r = a | b;
      OP_XOR:     r = a ^ b;
      OP_NOT_A:   r = ~a & mask;
      OP_SLL:     r = (a << sh) & mask;
      OP_SRL:     r = a >> sh;
      OP_SRA:     r = 64'(sa >>> sh) & mask;
      OP_MUL:     r = (a * b) & mask;
      OP_CMP_LT:  r = (sa < sb) ? 64'd1 : 64'd0;
      OP_CMP_LTU: r = (a < b) ? 64'd1 : 64'd0;
      default:    return 68'd0;
    endcase
    return {r[w-1], (r == 64'd0), c, v, r};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 4))
      0:       return 64'd0;
      1:       return {64{1'b1}};
      2:       return 64'h8000_0000_8000_0080;
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.op = 4'($urandom_range(0, 15));
    s.a  = pick();
    s.b  = pick();
    return s;
  endfunction

  task automatic drive();
    vld8  = (pend8.size() != 0);
    op8   = 4'h0; a8 = 8'h00; b8 = 8'h00;
    if (vld8) begin
      op8 = pend8[0].op; a8 = pend8[0].a[7:0]; b8 = pend8[0].b[7:0];
    end
    vld32 = (pend32.size() != 0);
    op32  = 4'h0; a32 = 32'h0; b32 = 32'h0;
    if (vld32) begin
      op32 = pend32[0].op; a32 = pend32[0].a[31:0]; b32 = pend32[0].b[31:0];
    end
  endtask

  // Scores the handshakes that the coming rising edge will perform.
  task automatic tick();
    logic [67:0] e;
    stim_t       s;
    int          t;
    #1;
    if (hold8)  check_eq("hold8",  64'({ovld8, flg8, res8}), hold8_val);
    if (hold32) check_eq("hold32", 64'({ovld32, flg32, res32}), hold32_val);
    hold8      = ovld8 && !ordy8;
    hold8_val  = 64'({ovld8, flg8, res8});
    hold32     = ovld32 && !ordy32;
    hold32_val = 64'({ovld32, flg32, res32});

    if (ovld8 && ordy8) begin
      outs8++;
      check_eq("sb8_pending", 64'(q8.size() != 0), 64'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        t = accq8.pop_front();
        check_eq("sb8_res",   64'(res8), e[63:0]);
        check_eq("sb8_flags", 64'(flg8), 64'(e[67:64]));
        last_lat8 = cyc - t; last_res8 = res8; last_flg8 = flg8;
      end
    end
    if (ovld32 && ordy32) begin
      outs32++;
      check_eq("sb32_pending", 64'(q32.size() != 0), 64'd1);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        t = accq32.pop_front();
        check_eq("sb32_res",   64'(res32), e[63:0]);
        check_eq("sb32_flags", 64'(flg32), 64'(e[67:64]));
        last_lat32 = cyc - t; last_res32 = res32; last_flg32 = flg32;
      end
    end
    if (vld8 && irdy8) begin
      q8.push_back(ref_alu(8, op8, 64'(a8), 64'(b8)));
      accq8.push_back(cyc);
      accs8++;
      if (op8 >= 4'hC) exp_icnt8++;
      s = pend8.pop_front();
    end
    if (vld32 && irdy32) begin
      q32.push_back(ref_alu(32, op32, 64'(a32), 64'(b32)));
      accq32.push_back(cyc);
      accs32++;
      if (op32 >= 4'hC) exp_icnt32++;
      s = pend32.pop_front();
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic step();
    drive();
    tick();
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((pend8.size() + q8.size() + pend32.size() + q32.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    check_eq("drain", 64'(pend8.size() + q8.size() + pend32.size() + q32.size()), 64'd0);
  endtask

  initial begin
    int acc_base, out_base;
    rst = 1'b1;
    ordy8 = 1'b1; ordy32 = 1'b1;
    drive();
    #1;
    check_eq("rst_ovld8",  64'(ovld8), 64'd0);
    check_eq("rst_res8",   64'(res8),  64'd0);
    check_eq("rst_flags8", 64'(flg8),  64'd0);
    check_eq("rst_icnt8",  64'(icnt8), 64'd0);
    check_eq("rst_irdy8",  64'(irdy8), 64'd1);
    check_eq("rst_irdy32", 64'(irdy32), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ADD wrapping to zero
    pend8.push_back('{OP_ADD, 64'hFF, 64'h01});
    run_until_idle(40);
    check_eq("add_lat",   64'(last_lat8), 64'd2);
    check_eq("add_res",   64'(last_res8), 64'h00);
    check_eq("add_flags", 64'(last_flg8), 64'b0110);

    // SUB with signed overflow
    pend8.push_back('{OP_SUB, 64'h80, 64'h01});
    run_until_idle(40);
    check_eq("sub_res",   64'(last_res8), 64'h7F);
    check_eq("sub_flags", 64'(last_flg8), 64'b0011);

    // Five back-to-back ops against a stalled consumer
    ordy8 = 1'b0;
    acc_base = accs8;
    out_base = outs8;
    for (int i = 1; i <= 5; i++) pend8.push_back('{OP_ADD, 64'(i), 64'(10 * i)});
    repeat (4) step();
    check_eq("bp_accepts", 64'(accs8 - acc_base), 64'd2);
    check_eq("bp_in_ready", 64'(irdy8), 64'd0);
    ordy8 = 1'b1;
    run_until_idle(60);
    check_eq("bp_out_count", 64'(outs8 - out_base), 64'd5);

    // Illegal opcode twice
    pend8.push_back('{4'hF, 64'h5A, 64'hA5});
    pend8.push_back('{4'hF, 64'hFF, 64'h01});
    run_until_idle(40);
    check_eq("illegal_res",   64'(last_res8), 64'd0);
    check_eq("illegal_flags", 64'(last_flg8), 64'd0);
    check_eq("illegal_cnt",   64'(icnt8), 64'd2);

    // Wide instance: arithmetic shift and truncated multiply
    pend32.push_back('{OP_SRA, 64'h8000_0000, 64'd31});
    run_until_idle(60);
    check_eq("sra32_lat", 64'(last_lat32), 64'd4);
    check_eq("sra32_res", 64'(last_res32), 64'hFFFF_FFFF);
    pend32.push_back('{OP_MUL, 64'h1_0000, 64'h1_0000});
    run_until_idle(60);
    check_eq("mul32_res",   64'(last_res32), 64'd0);
    check_eq("mul32_flags", 64'(last_flg32), 64'b0100);

    // Reset with two operations in flight
    pend8.push_back('{OP_XOR, 64'h3C, 64'h0F});
    pend8.push_back('{OP_OR,  64'h01, 64'h80});
    step();
    step();
    rst = 1'b1;
    #1;
    check_eq("mid_rst_ovld8", 64'(ovld8), 64'd0);
    check_eq("mid_rst_res8",  64'(res8),  64'd0);
    check_eq("mid_rst_irdy8", 64'(irdy8), 64'd1);
    check_eq("mid_rst_icnt8", 64'(icnt8), 64'd0);
    q8.delete(); accq8.delete(); pend8.delete();
    q32.delete(); accq32.delete(); pend32.delete();
    hold8 = 1'b0; hold32 = 1'b0;
    exp_icnt8 = 0; exp_icnt32 = 0;
    @(negedge clk);
    rst = 1'b0;
    out_base = outs8;
    repeat (6) step();
    check_eq("no_stale", 64'(outs8 - out_base), 64'd0);
    check_eq("post_rst_irdy8", 64'(irdy8), 64'd1);

    // Randomized traffic with random consumer stalls
    for (int i = 0; i < 600; i++) begin
      if (pend8.size()  < 3 && $urandom_range(0, 3) != 0) pend8.push_back(rand_stim());
      if (pend32.size() < 3 && $urandom_range(0, 3) != 0) pend32.push_back(rand_stim());
      ordy8  = ($urandom_range(0, 3) != 0);
      ordy32 = ($urandom_range(0, 2) != 0);
      step();
    end
    ordy8 = 1'b1; ordy32 = 1'b1;
    run_until_idle(200);
    check_eq("rand_icnt8",  64'(icnt8),  64'(exp_icnt8));
    check_eq("rand_icnt32", 64'(icnt32), 64'(exp_icnt32));
    check_eq("rand_count8", 64'(outs8 - out_base), 64'(accs8 - accs8 + q8.size() + outs8 - out_base));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
